// File: rtl/serial_parity_checker.sv
// Receive side of the serial parity link: deserialises DATA_BITS data bits plus
// one parity bit, flags parity mismatches and keeps a saturating error count.
module serial_parity_checker #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned ODD_PARITY = 0,
   parameter int unsigned ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 x,
   input  logic                 x_valid,
   input  logic                 sof,
   output logic [DATA_BITS-1:0] data,
   output logic                 done,
   output logic                 parity_err,
   output logic                 frame_abort,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int unsigned CNT_W  = $clog2(DATA_BITS + 1);
   localparam logic        LP_ODD = 1'(ODD_PARITY);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY
   } state_t;

   state_t               r_state,   w_state_n;
   logic [DATA_BITS-1:0] r_shift,   w_shift_n;
   logic [CNT_W-1:0]     r_cnt,     w_cnt_n;
   logic                 r_par,     w_par_n;
   logic [DATA_BITS-1:0] r_data,    w_data_n;
   logic                 r_perr,    w_perr_n;
   logic                 r_done,    w_done_n;
   logic                 r_abort,   w_abort_n;
   logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt_n;
   logic                 w_err;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_par     <= 1'b0;
         r_data    <= '0;
         r_perr    <= 1'b0;
         r_done    <= 1'b0;
         r_abort   <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_state   <= w_state_n;
         r_shift   <= w_shift_n;
         r_cnt     <= w_cnt_n;
         r_par     <= w_par_n;
         r_data    <= w_data_n;
         r_perr    <= w_perr_n;
         r_done    <= w_done_n;
         r_abort   <= w_abort_n;
         r_err_cnt <= w_err_cnt_n;
      end
   end

   // Next-state logic; a qualified sof restarts the frame from any state
   always_comb begin
      w_state_n   = r_state;
      w_shift_n   = r_shift;
      w_cnt_n     = r_cnt;
      w_par_n     = r_par;
      w_data_n    = r_data;
      w_perr_n    = r_perr;
      w_err_cnt_n = r_err_cnt;
      w_done_n    = 1'b0;
      w_abort_n   = 1'b0;
      w_err       = (r_par ^ x) != LP_ODD;

      if (x_valid) begin
         if (sof) begin
            w_abort_n = (r_state != S_IDLE);
            w_shift_n = DATA_BITS'(x);
            w_par_n   = x;
            w_cnt_n   = CNT_W'(1);
            w_state_n = S_DATA;
         end else begin
            unique case (r_state)
               S_DATA: begin
                  w_shift_n = r_shift | (DATA_BITS'(x) << r_cnt);
                  w_par_n   = r_par ^ x;
                  w_cnt_n   = r_cnt + CNT_W'(1);
                  if (r_cnt == CNT_W'(DATA_BITS - 1)) begin
                     w_state_n = S_PARITY;
                  end
               end
               S_PARITY: begin
                  w_data_n = r_shift;
                  w_perr_n = w_err;
                  w_done_n = 1'b1;
                  if (w_err && (r_err_cnt != '1)) begin
                     w_err_cnt_n = r_err_cnt + ERR_CNT_W'(1);
                  end
                  w_cnt_n   = '0;
                  w_par_n   = 1'b0;
                  w_state_n = S_IDLE;
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign data        = r_data;
   assign done        = r_done;
   assign parity_err  = r_perr;
   assign frame_abort = r_abort;
   assign err_count   = r_err_cnt;

endmodule
